// File: rtl/ras_unit_pkg.sv
// rtl/ras_unit_pkg.sv - shared types and helpers for the return address stack
// Purpose: per-cycle operation encoding and its priority decode, plus the
//          overflow counter ceiling, shared by the stack and anything that
//          inspects it.
// Ports:   none (package)
package ras_unit_pkg;

    localparam logic [7:0] OVF_CNT_MAX = 8'hFF;

    // One operation is applied per cycle.
    // OP_REPLACE is push and pop together on a non-empty stack.
    typedef enum logic [2:0] {
        OP_HOLD    = 3'd0,
        OP_FLUSH   = 3'd1,
        OP_PUSH    = 3'd2,
        OP_POP     = 3'd3,
        OP_REPLACE = 3'd4
    } ras_op_e;

    // Priority: flush > push&pop > push > pop > hold.
    // Push and pop together on an empty stack degrade to a plain push.
    // A pop on an empty stack degrades to hold.
    function automatic ras_op_e ras_decode(input logic flush,
                                           input logic push,
                                           input logic pop,
                                           input logic nonempty);
        if (flush)
            return OP_FLUSH;
        else if (push && pop && nonempty)
            return OP_REPLACE;
        else if (push)
            return OP_PUSH;
        else if (pop && nonempty)
            return OP_POP;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/ras_unit_if.sv
// rtl/ras_unit_if.sv - call/return request and prediction bundle for ras_unit
// Purpose: groups the frontend control/data inputs and the prediction outputs
//          of the return address stack.
// Ports:   flush_i, push_i, pop_i, data_i   requests from the frontend
//          valid_o, ra_o, count_o, ovf_cnt_o prediction and status
// Modports: master (frontend side), slave (ras_unit side)
interface ras_unit_if #(
    parameter int DEPTH = 2,
    parameter int VLEN  = 32
);
    logic                       flush_i;
    logic                       push_i;
    logic                       pop_i;
    logic [VLEN-1:0]            data_i;
    logic                       valid_o;
    logic [VLEN-1:0]            ra_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic [7:0]                 ovf_cnt_o;

    modport master (
        output flush_i, push_i, pop_i, data_i,
        input  valid_o, ra_o, count_o, ovf_cnt_o
    );

    modport slave (
        input  flush_i, push_i, pop_i, data_i,
        output valid_o, ra_o, count_o, ovf_cnt_o
    );
endinterface

// File: rtl/ras_unit.sv
// rtl/ras_unit.sv - circular return address stack with overwrite-on-full
// Purpose: predicts return addresses. Calls push, returns pop, and both
//          together replace the top entry. When the stack is full, a push
//          overwrites the oldest entry.
// Ports:   clk_i  core clock
//          rst_i  synchronous active-high reset
//          bus    ras_unit_if.slave (flush/push/pop/data in; valid/ra/count/ovf_cnt out)
// Config:  RAS_OVF_CNT_EN - when defined, ovf_cnt_o is a saturating count of
//          pushes that overwrote an entry. When undefined, ovf_cnt_o is tied to 0.
module ras_unit
    import ras_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int VLEN  = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    ras_unit_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ras_unit: DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] ra;
    } ras_t;

    ras_t            stack_q [DEPTH];
    logic [PW-1:0]   tp_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   tp_inc;
    logic [PW-1:0]   tp_dec;
    logic            full;
    ras_op_e         op;

    // DEPTH is a power of two, so the pointer wraps without an explicit modulo.
    assign tp_inc = tp_q + PW'(1);
    assign tp_dec = tp_q - PW'(1);
    assign full   = (cnt_q == CW'(DEPTH));
    assign op     = ras_decode(bus.flush_i, bus.push_i, bus.pop_i, cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                stack_q[i].valid <= 1'b0;
            tp_q  <= '0;
            cnt_q <= '0;
        end else begin
            unique case (op)
                OP_FLUSH: begin
                    for (int i = 0; i < DEPTH; i++)
                        stack_q[i].valid <= 1'b0;
                    tp_q  <= '0;
                    cnt_q <= '0;
                end
                OP_PUSH: begin
                    // When the stack is full, tp_inc points at the oldest
                    // entry, so this write overwrites it.
                    stack_q[tp_inc] <= '{valid: 1'b1, ra: bus.data_i};
                    tp_q            <= tp_inc;
                    if (!full)
                        cnt_q <= cnt_q + CW'(1);
                end
                OP_POP: begin
                    stack_q[tp_q].valid <= 1'b0;
                    tp_q                <= tp_dec;
                    cnt_q               <= cnt_q - CW'(1);
                end
                OP_REPLACE: begin
                    stack_q[tp_q] <= '{valid: 1'b1, ra: bus.data_i};
                end
                default: ;
            endcase
        end
    end

`ifdef RAS_OVF_CNT_EN
    logic [7:0] ovf_q;

    // Flush does not clear this counter. Only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            ovf_q <= '0;
        else if (op == OP_PUSH && full && ovf_q != OVF_CNT_MAX)
            ovf_q <= ovf_q + 8'd1;
    end

    assign bus.ovf_cnt_o = ovf_q;
`else
    assign bus.ovf_cnt_o = 8'd0;
`endif

    assign bus.valid_o = stack_q[tp_q].valid;
    assign bus.ra_o    = stack_q[tp_q].valid ? stack_q[tp_q].ra : '0;
    assign bus.count_o = cnt_q;

endmodule

// File: tb/tb_ras_unit.sv
// tb/tb_ras_unit.sv - randomized self-checking bench for ras_unit against a queue model
module tb_ras_unit;

    localparam int DEPTH = 2;
    localparam int VLEN  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ras_unit_if #(.DEPTH(DEPTH), .VLEN(VLEN)) bus ();

    ras_unit #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the back of the queue is the top of the stack.
    // The front of the queue is the oldest entry and is dropped when a push
    // exceeds DEPTH.
    logic [VLEN-1:0] model_q[$];
    int              model_ovf = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_apply(input logic r, input logic f, input logic pu,
                               input logic po, input logic [VLEN-1:0] d);
        if (r) begin
            model_q.delete();
            model_ovf = 0;
        end else if (f) begin
            model_q.delete();
        end else if (pu && po && model_q.size() > 0) begin
            model_q[model_q.size() - 1] = d;
        end else if (pu) begin
            model_q.push_back(d);
            if (model_q.size() > DEPTH) begin
                void'(model_q.pop_front());
`ifdef RAS_OVF_CNT_EN
                if (model_ovf < 255) model_ovf++;
`endif
            end
        end else if (po && model_q.size() > 0) begin
            void'(model_q.pop_back());
        end
    endtask

    task automatic step(input logic r, input logic f, input logic pu,
                        input logic po, input logic [VLEN-1:0] d);
        @(negedge clk);
        rst         = r;
        bus.flush_i = f;
        bus.push_i  = pu;
        bus.pop_i   = po;
        bus.data_i  = d;
        @(posedge clk);
        model_apply(r, f, pu, po, d);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic            ev;
        logic [VLEN-1:0] er;
        ev = model_q.size() > 0;
        er = ev ? model_q[model_q.size() - 1] : '0;
        check({tag, "_valid"}, 64'(bus.valid_o),   64'(ev));
        check({tag, "_ra"},    64'(bus.ra_o),      64'(er));
        check({tag, "_count"}, 64'(bus.count_o),   64'(model_q.size()));
        check({tag, "_ovf"},   64'(bus.ovf_cnt_o), 64'(model_ovf));
    endtask

    task automatic idle();  step(0, 0, 0, 0, '0); endtask
    task automatic push(input logic [VLEN-1:0] d); step(0, 0, 1, 0, d); endtask
    task automatic pop();   step(0, 0, 0, 1, '0); endtask

    logic [7:0] ovf_full;
    logic [7:0] ovf_one;

    initial begin
`ifdef RAS_OVF_CNT_EN
        ovf_full = 8'd255;
        ovf_one  = 8'd1;
`else
        ovf_full = 8'd0;
        ovf_one  = 8'd0;
`endif
        rst = 1'b1;
        bus.flush_i = 0; bus.push_i = 0; bus.pop_i = 0; bus.data_i = '0;

        // After reset, stay idle for three cycles.
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) idle();
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_ra",    64'(bus.ra_o),    64'd0);
        check("rst_count", 64'(bus.count_o), 64'd0);
        check("rst_ovf",   64'(bus.ovf_cnt_o), 64'd0);

        // Basic push/pop, and a pop when the stack is empty.
        push('h100); push('h200);
        check("pp_ra2", 64'(bus.ra_o), 64'h200);
        check("pp_cnt2", 64'(bus.count_o), 64'd2);
        pop();
        check("pp_ra1", 64'(bus.ra_o), 64'h100);
        check("pp_cnt1", 64'(bus.count_o), 64'd1);
        pop();
        check("pp_valid0", 64'(bus.valid_o), 64'd0);
        check("pp_cnt0", 64'(bus.count_o), 64'd0);
        pop();
        check_all("pop_empty");

        // Push when full: the oldest entry is overwritten.
        step(1, 0, 0, 0, '0);
        push('h100); push('h200); push('h300);
        check("ov_cnt", 64'(bus.count_o), 64'd2);
        check("ov_ra", 64'(bus.ra_o), 64'h300);
        check("ov_ovf", 64'(bus.ovf_cnt_o), 64'(ovf_one));
        pop();
        check("ov_pop_ra", 64'(bus.ra_o), 64'h200);
        pop();
        check("ov_pop_valid", 64'(bus.valid_o), 64'd0);

        // Push and pop in the same cycle, on a non-empty stack and on an empty one.
        step(1, 0, 0, 0, '0);
        push('h100);
        step(0, 0, 1, 1, 'h400);
        check("rep_ra", 64'(bus.ra_o), 64'h400);
        check("rep_cnt", 64'(bus.count_o), 64'd1);
        pop();
        step(0, 0, 1, 1, 'h500);
        check("rep_empty_ra", 64'(bus.ra_o), 64'h500);
        check("rep_empty_cnt", 64'(bus.count_o), 64'd1);

        // Flush wins over a push in the same cycle; the overflow count is kept.
        push('h600); push('h650); push('h680);
        step(0, 1, 1, 0, 'h700);
        check("fl_valid", 64'(bus.valid_o), 64'd0);
        check("fl_count", 64'(bus.count_o), 64'd0);
        check_all("fl");

        // Saturate the overflow counter, then reset during a push.
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 300; i++) push(VLEN'(i * 4));
        check("sat_ovf", 64'(bus.ovf_cnt_o), 64'(ovf_full));
        check_all("sat");
        step(1, 0, 1, 0, 'hABC);
        check("rst_mid_valid", 64'(bus.valid_o), 64'd0);
        check("rst_mid_ra",    64'(bus.ra_o),    64'd0);
        check("rst_mid_count", 64'(bus.count_o), 64'd0);
        check("rst_mid_ovf",   64'(bus.ovf_cnt_o), 64'd0);

        // Random mix of operations, checked against the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic r, f, pu, po;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 24) == 0);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            step(r, f, pu, po, VLEN'($urandom));
            check_all("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ras_unit.md
RAS_UNIT -- requirements
Module: ras_unit

Interface
REQ-001 Parameter DEPTH, default 2, number of return-address entries; SHALL be a power of two >= 2, else elaboration SHALL fail.
REQ-002 Parameter VLEN, default 32, width of stored virtual return address.
REQ-003 clk_i  input  1  core clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 flush_i  input  1  discard all entries (mispredict/exception flush).
REQ-006 push_i  input  1  call detected; push data_i.
REQ-007 pop_i  input  1  return detected; pop top entry.
REQ-008 data_i  input  VLEN  return address to push.
REQ-009 valid_o  output  1  top entry holds a valid prediction.
REQ-010 ra_o  output  VLEN  predicted return address (top entry).
REQ-011 count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 ovf_cnt_o  output  8  saturating count of overflow pushes.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH entries {valid, ra} with top pointer tp (mod DEPTH) and occupancy cnt.
REQ-014 valid_o/ra_o SHALL be combinational reads of entry[tp]; ra_o SHALL be 0 when valid_o=0; updates from a cycle's push/pop SHALL be visible the next cycle.
REQ-015 Priority per cycle: flush_i > push_i&pop_i > push_i > pop_i > hold.
REQ-016 flush_i: all valid bits cleared, tp=0, cnt=0 next cycle; push_i/pop_i in same cycle ignored; ovf_cnt_o not cleared.
REQ-017 push only: tp<=tp+1 mod DEPTH, entry[new tp]<={1,data_i}, cnt<=min(cnt+1,DEPTH).
REQ-018 push only with cnt==DEPTH (full): oldest entry silently overwritten (wrap-around), cnt stays DEPTH, overflow event raised.
REQ-019 pop only with cnt>0: entry[tp].valid<=0, tp<=tp-1 mod DEPTH, cnt<=cnt-1.
REQ-020 pop only with cnt==0 (empty): no state change, no error.
REQ-021 push&pop with cnt>0: entry[tp]<={1,data_i}; tp and cnt unchanged; not an overflow.
REQ-022 push&pop with cnt==0: behaves as push only (cnt becomes 1).

Reset
REQ-023 While rst_i=1 at a clock edge: all valid bits 0, tp=0, cnt=0, ovf_cnt=0; hence valid_o=0, ra_o=0, count_o=0, ovf_cnt_o=0 the following cycle.
REQ-024 Reset SHALL override flush/push/pop in the same cycle; ra payload storage need not be reset.

Configuration
REQ-025 Macro RAS_OVF_CNT_EN defined: ovf_cnt_o increments by 1 on each overflow event (REQ-018), saturating at 255.
REQ-026 Macro RAS_OVF_CNT_EN undefined: no counter flops; ovf_cnt_o tied to 0; all other behaviour identical.

Structure
REQ-027 Entry typedef ras_t {logic valid; logic [VLEN-1:0] ra;} SHALL live in the shared core package; DEPTH SHALL be driven from CVA6Cfg.RASDepth at instantiation in the frontend.
REQ-028 Single flat module; no sub-module required.

Verification
REQ-029 Reset then idle 3 cycles -> valid_o=0, ra_o=0, count_o=0, ovf_cnt_o=0.
REQ-030 DEPTH=2: push 0x100, push 0x200 -> ra_o=0x200, count_o=2; pop -> ra_o=0x100, count_o=1; pop -> valid_o=0, count_o=0; pop again -> no change.
REQ-031 DEPTH=2: push 0x100,0x200,0x300 -> count_o=2, ra_o=0x300, ovf_cnt_o=1 (macro on) / 0 (off); pop -> ra_o=0x200; pop -> valid_o=0.
REQ-032 Push 0x100, then push&pop with 0x400 -> ra_o=0x400, count_o=1; push&pop on empty stack with 0x500 -> ra_o=0x500, count_o=1.
REQ-033 Two entries stacked, flush_i=1 with push_i=1 (0x700) same cycle -> valid_o=0, count_o=0 next cycle, ovf_cnt_o unchanged.
REQ-034 Macro on, DEPTH=2: 300 pushes -> ovf_cnt_o=255; rst_i asserted mid-sequence during push -> all outputs 0 next cycle.
